// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake between the fetch unit (master) and imem (slave).
interface fetch_unit_if #(
  parameter int unsigned PC_WIDTH = 12
);
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_req;
  logic [31:0]         imem_rdata;
  logic                imem_valid;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem handshake, IR with one-entry skid buffer,
// decoded instruction fields and PC redirect.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int unsigned         PC_WIDTH = 12,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  fetch_unit_if.master        imem,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                ir_valid,
  output logic [31:0]         ir,
  output logic [PC_WIDTH-1:0] ir_pc,
  output logic [PC_WIDTH-1:0] ir_pc_plus1,
  output logic [4:0]          opcode,
  output logic [4:0]          rd,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          shamt,
  output logic [4:0]          aluop,
  output logic [16:0]         imm,
  output logic [26:0]         target
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic [PC_WIDTH-1:0] ir_pc_q, ir_pc_d;
  logic                ir_valid_q, ir_valid_d;
  logic [31:0]         skid_q, skid_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic                xfer;
  logic                consume;

  // Request is issued only while fetching; FULL holds off until the skid drains.
  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;

  assign xfer    = (state_q == S_FETCH) && imem.imem_valid;
  assign consume = ir_valid_q && !stall;

  // Next-state: redirect wins; otherwise fetch, skid or drain depending on state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    skid_d     = skid_q;
    skid_pc_d  = skid_pc_q;

    if (redirect) begin
      pc_d       = redirect_pc;
      ir_valid_d = 1'b0;
      ir_d       = '0;
      state_d    = S_FETCH;
    end else begin
      unique case (state_q)
        S_BOOT: begin
          state_d = S_FETCH;
          if (consume) begin
            ir_valid_d = 1'b0;
            ir_d       = '0;
          end
        end
        S_FETCH: begin
          if (xfer) begin
            pc_d = pc_q + PC_WIDTH'(1);
            if (!ir_valid_q || !stall) begin
              ir_d       = imem.imem_rdata;
              ir_pc_d    = pc_q;
              ir_valid_d = 1'b1;
            end else begin
              skid_d    = imem.imem_rdata;
              skid_pc_d = pc_q;
              state_d   = S_FULL;
            end
          end else if (consume) begin
            ir_valid_d = 1'b0;
            ir_d       = '0;
          end
        end
        S_FULL: begin
          if (!stall) begin
            ir_d    = skid_q;
            ir_pc_d = skid_pc_q;
            state_d = S_FETCH;
          end
        end
        default: begin
          state_d = S_BOOT;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      skid_q     <= '0;
      skid_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      skid_q     <= skid_d;
      skid_pc_q  <= skid_pc_d;
    end
  end

  // IR is held at zero while invalid, so fields decode to a nop bubble.
  assign ir_valid    = ir_valid_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_pc_plus1 = ir_pc_q + PC_WIDTH'(1);
  assign opcode      = ir_q[31:27];
  assign rd          = ir_q[26:22];
  assign rs          = ir_q[21:17];
  assign rt          = ir_q[16:12];
  assign shamt       = ir_q[11:7];
  assign aluop       = ir_q[6:2];
  assign imm         = ir_q[16:0];
  assign target      = ir_q[26:0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Saturating counters: accepted fetches and cycles the IR is held by stall.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (xfer && !redirect && (perf_fetched_q != 32'hFFFF_FFFF)) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (ir_valid_q && stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched      = perf_fetched_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table plus randomized
// run against a queue-based reference model.
module tb_fetch_unit;

  localparam int unsigned PW = 12;

  logic          clock;
  logic          reset;
  logic          stall;
  logic          redirect;
  logic [PW-1:0] redirect_pc;
  logic          ival;
  logic          ir_valid;
  logic [31:0]   ir;
  logic [PW-1:0] ir_pc;
  logic [PW-1:0] ir_pc_plus1;
  logic [4:0]    opcode, rd, rs, rt, shamt, aluop;
  logic [16:0]   imm;
  logic [26:0]   target;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_stall_cycles;
`endif

  int n_tests;
  int n_fail;

  fetch_unit_if #(.PC_WIDTH(PW)) imem_bus ();

  function automatic logic [31:0] mem_word(input logic [PW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A3C_0F96;
  endfunction

  assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
  assign imem_bus.imem_valid = ival;

  fetch_unit #(.PC_WIDTH(PW), .RESET_PC(12'h000)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem        (imem_bus.master),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ir_valid    (ir_valid),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_pc_plus1 (ir_pc_plus1),
    .opcode      (opcode),
    .rd          (rd),
    .rs          (rs),
    .rt          (rt),
    .shamt       (shamt),
    .aluop       (aluop),
    .imm         (imm),
    .target      (target)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare all visible outputs against an expected IR occupancy, PC and fetch port state.
  task automatic check_outputs(input string tag, input logic exp_valid, input logic [PW-1:0] exp_pc,
                               input logic exp_req, input logic [PW-1:0] exp_addr);
    logic [31:0] w;
    w = exp_valid ? mem_word(exp_pc) : 32'h0;
    check({tag, ".ir_valid"}, 64'(ir_valid), 64'(exp_valid));
    check({tag, ".ir"},       64'(ir),       64'(w));
    check({tag, ".req"},      64'(imem_bus.imem_req),  64'(exp_req));
    check({tag, ".addr"},     64'(imem_bus.imem_addr), 64'(exp_addr));
    check({tag, ".opcode"},   64'(opcode),   64'(5'(w >> 27)));
    check({tag, ".rd"},       64'(rd),       64'(5'(w >> 22)));
    check({tag, ".rs"},       64'(rs),       64'(5'(w >> 17)));
    check({tag, ".rt"},       64'(rt),       64'(5'(w >> 12)));
    check({tag, ".shamt"},    64'(shamt),    64'(5'(w >> 7)));
    check({tag, ".aluop"},    64'(aluop),    64'(5'(w >> 2)));
    check({tag, ".imm"},      64'(imm),      64'(w % 32'h2_0000));
    check({tag, ".target"},   64'(target),   64'(w % 32'h800_0000));
    if (exp_valid) begin
      check({tag, ".ir_pc"},       64'(ir_pc),       64'(exp_pc));
      check({tag, ".ir_pc_plus1"}, 64'(ir_pc_plus1), 64'((32'(exp_pc) + 32'd1) % 32'h1000));
    end
  endtask

  typedef struct {
    logic          stall;
    logic          ival;
    logic          redir;
    logic [PW-1:0] rpc;
    logic          exp_valid;
    logic [PW-1:0] exp_pc;
    logic          exp_req;
    logic [PW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[22];

  task automatic apply_vec(input int i);
    stall       = vecs[i].stall;
    ival        = vecs[i].ival;
    redirect    = vecs[i].redir;
    redirect_pc = vecs[i].rpc;
    @(posedge clock);
    @(negedge clock);
    check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                  vecs[i].exp_req, vecs[i].exp_addr);
  endtask

  // Reference model: queue of fetched PCs (IR first, skid second), fetch PC, boot flag.
  logic [PW-1:0] q_pc[$];
  logic [PW-1:0] m_pc;
  logic          m_boot;
  logic [31:0]   m_fetched;
  logic [31:0]   m_stallc;

  task automatic model_reset();
    q_pc.delete();
    m_pc      = 12'h000;
    m_boot    = 1'b1;
    m_fetched = 32'd0;
    m_stallc  = 32'd0;
  endtask

  initial begin
    logic          exp_valid;
    logic [PW-1:0] exp_pc;
    logic          exp_req;
    logic          xf;

    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    ival        = 1'b0;

    //           stall ival redir rpc      valid pc       req addr
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 12'h000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 12'h000, 1'b1, 12'h001};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 12'h001, 1'b1, 12'h002};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 12'h002, 1'b1, 12'h003};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h002, 1'b0, 12'h004};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h002, 1'b0, 12'h004};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h002, 1'b0, 12'h004};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 12'h003, 1'b1, 12'h004};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 12'h004, 1'b1, 12'h005};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 12'h020, 1'b0, 12'h000, 1'b1, 12'h020};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 12'h020, 1'b1, 12'h021};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h020, 1'b0, 12'h022};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 12'h040, 1'b0, 12'h000, 1'b1, 12'h040};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 12'h040};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h040, 1'b1, 12'h041};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 12'hFFF, 1'b0, 12'h000, 1'b1, 12'hFFF};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 12'hFFF, 1'b1, 12'h000};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 12'h000};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 12'h000, 1'b1, 12'h001};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h000, 1'b0, 12'h002};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 12'h000};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 12'h000, 1'b1, 12'h001};

    // Reset state.
    @(negedge clock);
    check_outputs("reset", 1'b0, 12'h000, 1'b0, 12'h000);
    check("reset.ir_pc", 64'(ir_pc), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    check_outputs("boot", 1'b0, 12'h000, 1'b0, 12'h000);

    // Streaming, stall/skid, redirects, PC wrap, then reach FULL.
    for (int i = 0; i < 20; i++) apply_vec(i);

    // Asynchronous reset while FULL: outputs clear without a clock edge.
    #2 reset = 1'b0;
    #1;
    check_outputs("async_rst", 1'b0, 12'h000, 1'b0, 12'h000);
    check("async_rst.ir_pc", 64'(ir_pc), 64'(0));
`ifdef FETCH_PERF_CNT_EN
    check("async_rst.perf_fetched", 64'(perf_fetched), 64'(0));
    check("async_rst.perf_stall",   64'(perf_stall_cycles), 64'(0));
`endif
    @(negedge clock);
    reset = 1'b1;
    for (int i = 20; i < 22; i++) apply_vec(i);

    // Randomized run against the reference model.
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    ival = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      exp_valid = (q_pc.size() > 0);
      exp_pc    = exp_valid ? q_pc[0] : 12'h000;
      exp_req   = !m_boot && (q_pc.size() < 2);
      check_outputs($sformatf("rnd%0d", cyc), exp_valid, exp_pc, exp_req, m_pc);
`ifdef FETCH_PERF_CNT_EN
      check("rnd.perf_fetched", 64'(perf_fetched), 64'(m_fetched));
      check("rnd.perf_stall",   64'(perf_stall_cycles), 64'(m_stallc));
`endif
      stall    = ($urandom_range(0, 9) < 3);
      ival     = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 29) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 12'hFFE : 12'($urandom);

      xf = exp_req && ival;
      if (exp_valid && stall && m_stallc != 32'hFFFF_FFFF) m_stallc++;
      if (redirect) begin
        m_pc = redirect_pc;
        q_pc.delete();
      end else begin
        if (exp_valid && !stall) void'(q_pc.pop_front());
        if (xf) begin
          q_pc.push_back(m_pc);
          m_pc = 12'((32'(m_pc) + 32'd1) % 32'h1000);
          if (m_fetched != 32'hFFFF_FFFF) m_fetched++;
        end
      end
      m_boot = 1'b0;
      @(posedge clock);
      @(negedge clock);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
